// File: rtl/spi_responder_pkg.sv
// Shared definitions for the SPI card-side command responder: command indices,
// R1 bit positions, FSM encoding and the filler byte.
package spi_responder_pkg;

  localparam logic [5:0] CMD_GO_IDLE         = 6'd0;
  localparam logic [5:0] CMD_SEND_IF_COND    = 6'd8;
  localparam logic [5:0] CMD_SET_BLOCKLEN    = 6'd16;
  localparam logic [5:0] CMD_READ_SINGLE     = 6'd17;
  localparam logic [5:0] CMD_SD_SEND_OP_COND = 6'd41;
  localparam logic [5:0] CMD_APP_CMD         = 6'd55;
  localparam logic [5:0] CMD_READ_OCR        = 6'd58;

  localparam int R1_IDLE_BIT    = 0;
  localparam int R1_ILLEGAL_BIT = 2;

  localparam logic [7:0] FILLER_BYTE = 8'hFF;
  localparam logic [2:0] TAIL_LEN_4  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NCR  = 3'd1,
    ST_R1   = 3'd2,
    ST_TAIL = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic [7:0] r1_byte(input logic illegal, input logic idle);
    logic [7:0] r1;
    r1                 = 8'h00;
    r1[R1_ILLEGAL_BIT] = illegal;
    r1[R1_IDLE_BIT]    = idle;
    return r1;
  endfunction

  // Tail bytes leave MSB first: index 0 is bits 31..24.
  function automatic logic [7:0] tail_byte(input logic [31:0] data, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = data[31:24];
      3'd1:    b = data[23:16];
      3'd2:    b = data[15:8];
      3'd3:    b = data[7:0];
      default: b = FILLER_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_responder_decoder.sv
// Combinational command decode: maps index plus current flags to the R1 byte,
// the tail payload and the updated idle/app flags.
module spi_responder_decoder
  import spi_responder_pkg::*;
(
  input  logic [5:0]  cmd,
  input  logic [11:0] arg_low,
  input  logic        app_flag,
  input  logic        idle_flag,
  input  logic [30:0] ocr_low,
  output logic [7:0]  r1,
  output logic [2:0]  tail_len,
  output logic [31:0] tail_data,
  output logic        next_idle,
  output logic        next_app,
  output logic        read_req
);

  logic illegal_s;

  // Decode one command against the current card flags.
  always_comb begin
    illegal_s = 1'b0;
    next_idle = idle_flag;
    next_app  = 1'b0;
    tail_len  = 3'd0;
    tail_data = 32'h0000_0000;
    read_req  = 1'b0;
    case (cmd)
      CMD_GO_IDLE: begin
        next_idle = 1'b1;
      end
      CMD_SEND_IF_COND: begin
        tail_len  = TAIL_LEN_4;
        tail_data = {16'h0000, 4'h0, arg_low};
      end
      CMD_APP_CMD: begin
        next_app = 1'b1;
      end
      CMD_SD_SEND_OP_COND: begin
        if (app_flag) begin
          next_idle = 1'b0;
        end else begin
          illegal_s = 1'b1;
        end
      end
      CMD_READ_OCR: begin
        tail_len  = TAIL_LEN_4;
        tail_data = {~idle_flag, ocr_low};
      end
      CMD_SET_BLOCKLEN: begin
        tail_len = 3'd0;
      end
      CMD_READ_SINGLE: begin
        if (idle_flag) begin
          illegal_s = 1'b1;
        end else begin
          read_req = 1'b1;
        end
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
    r1 = r1_byte(illegal_s, next_idle);
  end

endmodule

// File: rtl/spi_responder.sv
// SPI card responder: after each accepted command emits NCR filler bytes, the R1
// byte and an optional tail, and triggers the block read stage for CMD17.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int          NCR_BYTES = 1,
  parameter logic [31:0] OCR_LOW   = 32'h00FF_8000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_CommandValid,
  input  logic [5:0]  io_Command,
  input  logic [31:0] io_CommandArgument,
  output logic [7:0]  io_OutputByte,
  output logic        io_OutputValid,
  input  logic        io_OutputReady,
  output logic        io_Busy,
  output logic        io_InIdle,
  output logic        io_BlockReadRequest,
  output logic [31:0] io_BlockAddress
);

  localparam logic [2:0] NCR_LAST = 3'(NCR_BYTES - 1);

  state_t      state_r, state_s;
  logic [2:0]  cnt_r, cnt_s;
  logic        idle_r, idle_s;
  logic        app_r, app_s;
  logic [7:0]  r1_r, r1_s;
  logic [2:0]  tail_len_r, tail_len_s;
  logic [31:0] tail_data_r, tail_data_s;
  logic [31:0] arg_r, arg_s;
  logic        read_pend_r, read_pend_s;
  logic [7:0]  byte_r, byte_s;
  logic        valid_r, valid_s;
  logic        busy_r, busy_s;
  logic        req_r, req_s;
  logic [31:0] addr_r, addr_s;
  logic        xfer_s;

  logic [7:0]  dec_r1_s;
  logic [2:0]  dec_tail_len_s;
  logic [31:0] dec_tail_data_s;
  logic        dec_idle_s, dec_app_s, dec_read_s;

  spi_responder_decoder u_decoder (
    .cmd       (io_Command),
    .arg_low   (io_CommandArgument[11:0]),
    .app_flag  (app_r),
    .idle_flag (idle_r),
    .ocr_low   (OCR_LOW[30:0]),
    .r1        (dec_r1_s),
    .tail_len  (dec_tail_len_s),
    .tail_data (dec_tail_data_s),
    .next_idle (dec_idle_s),
    .next_app  (dec_app_s),
    .read_req  (dec_read_s)
  );

  // Next-state, counters and the next registered output byte.
  always_comb begin
    xfer_s      = valid_r & io_OutputReady;
    state_s     = state_r;
    cnt_s       = cnt_r;
    idle_s      = idle_r;
    app_s       = app_r;
    r1_s        = r1_r;
    tail_len_s  = tail_len_r;
    tail_data_s = tail_data_r;
    arg_s       = arg_r;
    read_pend_s = read_pend_r;
    req_s       = 1'b0;
    addr_s      = addr_r;
    case (state_r)
      ST_IDLE: begin
        if (io_CommandValid) begin
          state_s     = ST_NCR;
          cnt_s       = 3'd0;
          idle_s      = dec_idle_s;
          app_s       = dec_app_s;
          r1_s        = dec_r1_s;
          tail_len_s  = dec_tail_len_s;
          tail_data_s = dec_tail_data_s;
          read_pend_s = dec_read_s;
          arg_s       = io_CommandArgument;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_NCR: begin
        if (xfer_s && (cnt_r == NCR_LAST)) begin
          state_s = ST_R1;
          cnt_s   = 3'd0;
        end else if (xfer_s) begin
          cnt_s = cnt_r + 3'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_R1: begin
        if (xfer_s) begin
          state_s = (tail_len_r != 3'd0) ? ST_TAIL : ST_DONE;
          cnt_s   = 3'd0;
          req_s   = read_pend_r;
          addr_s  = read_pend_r ? arg_r : addr_r;
        end else begin
          state_s = ST_R1;
        end
      end
      ST_TAIL: begin
        if (xfer_s && (cnt_r == (tail_len_r - 3'd1))) begin
          state_s = ST_DONE;
        end else if (xfer_s) begin
          cnt_s = cnt_r + 3'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_DONE: begin
        state_s     = ST_IDLE;
        read_pend_s = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Output byte only changes with state/counter, hence only on a transfer.
    case (state_s)
      ST_NCR: begin
        valid_s = 1'b1;
        byte_s  = FILLER_BYTE;
      end
      ST_R1: begin
        valid_s = 1'b1;
        byte_s  = r1_s;
      end
      ST_TAIL: begin
        valid_s = 1'b1;
        byte_s  = tail_byte(tail_data_s, cnt_s);
      end
      default: begin
        valid_s = 1'b0;
        byte_s  = FILLER_BYTE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State register and registered outputs; reset aborts any response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      idle_r      <= 1'b1;
      app_r       <= 1'b0;
      r1_r        <= 8'h00;
      tail_len_r  <= 3'd0;
      tail_data_r <= 32'h0000_0000;
      arg_r       <= 32'h0000_0000;
      read_pend_r <= 1'b0;
      byte_r      <= FILLER_BYTE;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      req_r       <= 1'b0;
      addr_r      <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idle_r      <= idle_s;
      app_r       <= app_s;
      r1_r        <= r1_s;
      tail_len_r  <= tail_len_s;
      tail_data_r <= tail_data_s;
      arg_r       <= arg_s;
      read_pend_r <= read_pend_s;
      byte_r      <= byte_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
      req_r       <= req_s;
      addr_r      <= addr_s;
    end
  end

  assign io_OutputByte       = byte_r;
  assign io_OutputValid      = valid_r;
  assign io_Busy             = busy_r;
  assign io_InIdle           = idle_r;
  assign io_BlockReadRequest = req_r;
  assign io_BlockAddress     = addr_r;

endmodule
